// File: rtl/calc_pkg.sv
// calc_pkg: shared button constants, per-channel debounce FSM states and counter sizing.
package calc_pkg;

    localparam int NUM_BUTTONS = 9;

    localparam int BTN_DIG0 = 0;
    localparam int BTN_DIG1 = 1;
    localparam int BTN_DIG2 = 2;
    localparam int BTN_DIG3 = 3;
    localparam int BTN_ADD  = 4;
    localparam int BTN_SUB  = 5;
    localparam int BTN_MUL  = 6;
    localparam int BTN_DIV  = 7;
    localparam int BTN_SHOW = 8;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button levels in, debounced levels and press pulses out.
interface button_conditioner_if #(
    parameter int N = 9
);
    logic [N-1:0] buttons_raw;
    logic [N-1:0] buttons_level;
    logic [N-1:0] buttons_pulse;

    modport master (output buttons_raw, input buttons_level, input buttons_pulse);
    modport slave (input buttons_raw, output buttons_level, output buttons_pulse);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: one channel -- 2-flop synchronizer, debounce FSM and press pulse.
// Auto-repeat is compiled in only when BUTTON_AUTOREPEAT_EN is defined.
module button_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 5,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic pulse
);
    localparam int W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [W-1:0] DB_LAST = W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync;
    logic s;
    btn_state_t state, state_nx;
    logic [W-1:0] cnt, cnt_nx;
    logic press, rpt_fire;

    assign s = sync[1];
    assign level = state == HELD || state == RELEASE_WAIT;

    // The entry sample lives in IDLE/HELD, so the wait states need DEBOUNCE_CYCLES more.
    always_comb begin
        state_nx = state;
        cnt_nx = cnt + W'(cnt != '1);
        press = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx = s ? PRESS_WAIT : IDLE;
                cnt_nx = '0;
            end
            PRESS_WAIT: begin
                press = s && cnt == DB_LAST;
                state_nx = !s ? IDLE : press ? HELD : PRESS_WAIT;
            end
            HELD: begin
                state_nx = s ? HELD : RELEASE_WAIT;
                cnt_nx = '0;
            end
            RELEASE_WAIT: state_nx = s ? HELD : cnt == DB_LAST ? IDLE : RELEASE_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            state <= IDLE;
            cnt <= '0;
            pulse <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            state <= state_nx;
            cnt <= cnt_nx;
            pulse <= press | rpt_fire;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    logic [W-1:0] rpt;
    logic rpt_phase, held_on;

    // Timer runs only while staying in HELD; any exit or re-entry restarts the delay phase.
    assign held_on = REPEAT_EN && state == HELD && s;
    assign rpt_fire = held_on && rpt == (rpt_phase ? W'(REPEAT_PERIOD - 1) : W'(REPEAT_DELAY - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt <= '0;
            rpt_phase <= 1'b0;
        end else begin
            rpt <= held_on && !rpt_fire ? rpt + W'(rpt != '1) : '0;
            rpt_phase <= held_on && (rpt_phase || rpt_fire);
        end
    end
`else
    localparam bit unused_repeat_en = REPEAT_EN;
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: NUM_BUTTONS independent debounced channels with one-cycle press pulses.
// Define BUTTON_AUTOREPEAT_EN to add auto-repeat on the REPEAT_MASK channels.
module button_conditioner #(
    parameter int NUM_BUTTONS     = calc_pkg::NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK = 9'b000001111
) (
    input logic clk,
    input logic reset_n,
    button_conditioner_if.slave bus
);
    logic [NUM_BUTTONS-1:0] level, pulse;

    assign bus.buttons_level = level;
    assign bus.buttons_pulse = pulse;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .REPEAT_EN(REPEAT_MASK[i])
        ) u_deb (
            .clk(clk),
            .reset_n(reset_n),
            .raw(bus.buttons_raw[i]),
            .level(level[i]),
            .pulse(pulse[i])
        );
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_BUTTONS, default 9, number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a level change; legal range 2..2^20.
REQ-003 Parameter REPEAT_DELAY, default 25000000, held cycles before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PERIOD, default 10000000, cycles between subsequent auto-repeat pulses.
REQ-005 Parameter REPEAT_MASK, default 9'b000001111, channels eligible for auto-repeat (the digit buttons).
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 buttons_raw  input  NUM_BUTTONS  asynchronous, bouncing pushbutton levels, 1 = pressed.
REQ-009 buttons_level  output  NUM_BUTTONS  debounced, synchronous button levels.
REQ-010 buttons_pulse  output  NUM_BUTTONS  one-cycle press events, consumed by the calculator core as increment/operation strobes.

Function
REQ-011 Each channel SHALL pass through a 2-flop synchronizer before any other logic; sync output = s.
REQ-012 Each channel SHALL run an FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-013 IDLE: s=1 -> PRESS_WAIT with counter cleared; else stay.
REQ-014 PRESS_WAIT: s=0 -> IDLE (bounce rejected); s=1 for DEBOUNCE_CYCLES consecutive cycles -> HELD.
REQ-015 HELD: s=0 -> RELEASE_WAIT with counter cleared; else stay.
REQ-016 RELEASE_WAIT: s=1 -> HELD, with no new pulse; s=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
REQ-017 buttons_level[i] SHALL be 1 in HELD and RELEASE_WAIT, and 0 otherwise.
REQ-018 buttons_pulse[i] SHALL be 1 for exactly the one cycle after PRESS_WAIT->HELD.
REQ-019 Latency SHALL be exactly 2+DEBOUNCE_CYCLES cycles from the first clean-high raw sample to the pulse.
REQ-020 Counters SHALL be $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)+1) bits wide, saturate, and never wrap.
REQ-021 Channels SHALL be fully independent; simultaneous presses SHALL each produce their own pulse in the same cycle.
REQ-022 A raw glitch shorter than DEBOUNCE_CYCLES SHALL produce no level change and no pulse.

Reset
REQ-023 reset_n=0 SHALL asynchronously force all FSMs to IDLE, clear all counters and synchronizer flops, and drive buttons_level=0 and buttons_pulse=0.
REQ-024 A button held through reset release SHALL produce exactly one pulse, at 2+DEBOUNCE_CYCLES cycles after release.
REQ-025 Reset asserted mid-PRESS_WAIT or mid-HELD SHALL discard the pending event, with no pulse generated.

Configuration
REQ-026 Macro BUTTON_AUTOREPEAT_EN compiles auto-repeat in or out.
REQ-027 With BUTTON_AUTOREPEAT_EN defined, a channel with its REPEAT_MASK bit set, held continuously in HELD, SHALL pulse REPEAT_DELAY cycles after the initial pulse and then every REPEAT_PERIOD cycles.
REQ-028 With BUTTON_AUTOREPEAT_EN defined, any transition out of HELD SHALL clear the repeat timer.
REQ-029 Without BUTTON_AUTOREPEAT_EN, the repeat counters and REPEAT_* logic SHALL be absent; exactly one pulse per press.

Structure
REQ-030 Shared package calc_pkg SHALL hold NUM_BUTTONS, the button index constants (BTN_DIG0..BTN_DIG3=0..3, BTN_ADD=4, BTN_SUB=5, BTN_MUL=6, BTN_DIV=7, BTN_SHOW=8), and the FSM state enum.
REQ-031 Sub-module button_debounce (one channel: synchronizer, FSM, counters) SHALL be instantiated NUM_BUTTONS times via generate.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-032 Clean press: buttons_raw[0] rises and stays high -> single buttons_pulse[0] 6 cycles later; buttons_level[0]=1 from that cycle.
REQ-033 Bounce: raw[5] toggles 1,0,1,0 on successive cycles, then stays high -> no pulse during the toggling; one pulse 6 cycles after the final rise.
REQ-034 Release bounce: raw[4] held, then drops for 2 cycles and returns high -> level stays 1 and no second pulse.
REQ-035 Simultaneous: raw[2] and raw[7] rise in the same cycle -> both pulses asserted in the same cycle.
REQ-036 Reset mid-operation: reset_n low at cycle 3 of PRESS_WAIT -> outputs are 0 immediately; with the button still held, one pulse 6 cycles after reset_n rises.
REQ-037 Auto-repeat (macro defined): raw[1] held 40 cycles -> pulses at t, t+10, t+15, t+20, t+25, t+30; raw[6] held the same 40 cycles -> one pulse only.
